// File: rtl/isa_defs.sv
// isa_defs -- shared ISA definitions for the decode and execute stages.
//   Instruction field positions, opcode constants, opcode class encoding and
//   small decode helpers. No ports; imported with `import isa_defs::*;`.
package isa_defs;

   // Instruction field positions (LSB of each field)
   localparam int OP_LSB  = 26;
   localparam int RD_LSB  = 21;
   localparam int RS1_LSB = 16;
   localparam int RS2_LSB = 11;
   localparam int IMM_W   = 16;

   // Opcode constants
   localparam logic [5:0] OP_RTYPE    = 6'h00;
   localparam logic [5:0] OP_ITYPE_LO = 6'h01;
   localparam logic [5:0] OP_ITYPE_HI = 6'h0F;
   localparam logic [5:0] OP_ZEXT_LO  = 6'h0C;
   localparam logic [5:0] OP_ZEXT_HI  = 6'h0E;
   localparam logic [5:0] OP_LOAD     = 6'h10;
   localparam logic [5:0] OP_STORE    = 6'h11;
   localparam logic [5:0] OP_BEQ      = 6'h20;
   localparam logic [5:0] OP_HALT     = 6'h3F;
   localparam logic [5:0] OP_NOP      = 6'h00;

   typedef enum logic [2:0] {
      CLS_RTYPE  = 3'd0,
      CLS_ITYPE  = 3'd1,
      CLS_LOAD   = 3'd2,
      CLS_STORE  = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_HALT   = 3'd5,
      CLS_NOP    = 3'd6
   } op_class_e;

   function automatic op_class_e op_class(input logic [5:0] op);
      op_class_e c;
      if (op == OP_RTYPE)                               c = CLS_RTYPE;
      else if (op >= OP_ITYPE_LO && op <= OP_ITYPE_HI)  c = CLS_ITYPE;
      else if (op == OP_LOAD)                           c = CLS_LOAD;
      else if (op == OP_STORE)                          c = CLS_STORE;
      else if (op == OP_BEQ)                            c = CLS_BRANCH;
      else if (op == OP_HALT)                           c = CLS_HALT;
      else                                              c = CLS_NOP;
      return c;
   endfunction

   // Classes that actually read the rs2 field (the rest reuse those bits as imm)
   function automatic logic uses_rs2(input op_class_e c);
      return (c == CLS_RTYPE) || (c == CLS_STORE) || (c == CLS_BRANCH);
   endfunction

   // Logical immediates are zero-extended, everything else sign-extends
   function automatic logic imm_zext(input logic [5:0] op);
      return (op >= OP_ZEXT_LO) && (op <= OP_ZEXT_HI);
   endfunction

endpackage

// File: rtl/regfile.sv
// regfile -- 2-read / 1-write architectural register file with write-through.
//   clk, rst_n        : clock, synchronous active-low reset (clears all registers)
//   ra1/ra2, rd1/rd2  : combinational read ports
//   we, wa, wd        : write port, committed on the rising edge
// A read of the address being written in the same cycle returns wd, so decode
// never sees a stale value. With ZERO_REG, register 0 is hardwired to zero.
module regfile #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int ZERO_REG = 1,
   localparam int RAW     = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [RAW-1:0]  ra1,
   input  logic [RAW-1:0]  ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [RAW-1:0]  wa,
   input  logic [XLEN-1:0] wd
);

   logic [XLEN-1:0] regs [NREG];
   logic            wr_ok;

   // Writes to r0 are dropped entirely, which also disables its bypass
   assign wr_ok = we && !((ZERO_REG != 0) && (wa == '0));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wa] <= wd;
      end
   end

   always_comb begin
      rd1 = regs[ra1];
      if (wr_ok && (wa == ra1)) rd1 = wd;
      if ((ZERO_REG != 0) && (ra1 == '0)) rd1 = '0;
   end

   always_comb begin
      rd2 = regs[ra2];
      if (wr_ok && (wa == ra2)) rd2 = wd;
      if ((ZERO_REG != 0) && (ra2 == '0)) rd2 = '0;
   end

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage -- single-entry decode pipeline stage.
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_valid/in_ready          : fetch -> decode handshake
//   in_pc, in_instr            : fetched PC and instruction word
//   flush                      : drop the held result, leave HALTED
//   wb_en/wb_addr/wb_data      : register file write port
//   out_valid/out_ready        : decode -> execute handshake
//   out_pc, out_rs1_val, out_rs2_val, out_imm, out_op, out_rd, out_is_load
//                              : registered decode result
//   out_halted                 : FSM state (1 = HALTED)
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1; a producer holding valid keeps its data stable until that edge, and
// in_ready never depends on in_valid.
module instr_decode_stage
   import isa_defs::*;
#(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int ZERO_REG = 1,
   localparam int RAW     = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_instr,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [RAW-1:0]  wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1_val,
   output logic [XLEN-1:0] out_rs2_val,
   output logic [XLEN-1:0] out_imm,
   output logic [5:0]      out_op,
   output logic [RAW-1:0]  out_rd,
   output logic            out_is_load,
   output logic            out_halted
);

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   logic [0:0]      state;

   // Field extraction and decode of the offered instruction
   logic [5:0]      f_op;
   logic [RAW-1:0]  f_rd, f_rs1, f_rs2;
   logic [15:0]     f_imm;
   op_class_e       d_cls;
   logic [5:0]      d_op;
   logic [RAW-1:0]  d_rd;
   logic [XLEN-1:0] d_imm;
   logic            d_uses_rs2;
   logic [XLEN-1:0] rs1_val, rs2_val;

   assign f_op  = in_instr[OP_LSB +: 6];
   assign f_rd  = in_instr[RD_LSB +: RAW];
   assign f_rs1 = in_instr[RS1_LSB +: RAW];
   assign f_rs2 = in_instr[RS2_LSB +: RAW];
   assign f_imm = in_instr[IMM_W-1:0];

   assign d_cls      = op_class(f_op);
   assign d_uses_rs2 = uses_rs2(d_cls);

   always_comb begin
      d_op = f_op;
      d_rd = f_rd;
      // Unknown opcodes become a harmless NOP writing r0
      if (d_cls == CLS_NOP) begin
         d_op = OP_NOP;
         d_rd = '0;
      end
      if (imm_zext(f_op)) d_imm = {{(XLEN-IMM_W){1'b0}}, f_imm};
      else                d_imm = {{(XLEN-IMM_W){f_imm[IMM_W-1]}}, f_imm};
   end

   regfile #(
      .XLEN     (XLEN),
      .NREG     (NREG),
      .ZERO_REG (ZERO_REG)
   ) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (f_rs1),
      .ra2   (f_rs2),
      .rd1   (rs1_val),
      .rd2   (rs2_val),
      .we    (wb_en),
      .wa    (wb_addr),
      .wd    (wb_data)
   );

   // Handshake control. A load result is not available until after execute,
   // so a dependent instruction waits one cycle behind a bubble.
   logic hazard, advance, accept;

   assign hazard  = out_valid && out_is_load && (out_rd != '0) &&
                    ((out_rd == f_rs1) || (d_uses_rs2 && (out_rd == f_rs2)));
   assign advance = !out_valid || out_ready;
   assign in_ready = (state == ST_RUN) && !flush && !hazard && advance;
   assign accept  = in_valid && in_ready;

   assign out_halted = (state == ST_HALTED);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         out_valid   <= 1'b0;
         out_pc      <= '0;
         out_rs1_val <= '0;
         out_rs2_val <= '0;
         out_imm     <= '0;
         out_op      <= '0;
         out_rd      <= '0;
         out_is_load <= 1'b0;
      end else if (flush) begin
         // Flush wins over any accept in the same cycle
         state     <= ST_RUN;
         out_valid <= 1'b0;
      end else begin
         if (advance) begin
            // No accept on an advance (hazard, idle, halted) emits a bubble
            out_valid <= accept;
            if (accept) begin
               out_pc      <= in_pc;
               out_rs1_val <= rs1_val;
               out_rs2_val <= rs2_val;
               out_imm     <= d_imm;
               out_op      <= d_op;
               out_rd      <= d_rd;
               out_is_load <= (d_cls == CLS_LOAD);
            end
         end
         // The HALT itself is still presented downstream
         if (accept && (d_cls == CLS_HALT)) state <= ST_HALTED;
      end
   end

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

   localparam int XLEN = 32;
   localparam int RAW  = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [31:0]     in_instr;
   logic            flush;
   logic            wb_en;
   logic [RAW-1:0]  wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
   logic [5:0]      out_op;
   logic [RAW-1:0]  out_rd;
   logic            out_is_load;
   logic            out_halted;

   int total = 0;
   int bad   = 0;

   // clock / reset block
   always #5 clk = ~clk;

   instr_decode_stage #(.XLEN(32), .NREG(32), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
      .out_imm(out_imm), .out_op(out_op), .out_rd(out_rd),
      .out_is_load(out_is_load), .out_halted(out_halted)
   );

   // driver tasks: inputs change 1ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [XLEN-1:0] pc, input logic [31:0] instr);
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = instr;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_instr = 32'h0;
      in_pc    = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      out_ready = 1'b1;
      idle();
      tick(); tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      total++; if (out_halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b exp=0", out_halted); end
      total++; if ({out_pc, out_imm, out_rs1_val} !== 96'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {out_pc, out_imm, out_rs1_val}); end
      rst_n = 1'b1;
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
   endtask

   task automatic test_addi();
      offer(32'h100, 32'h0460FFFB);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL addi_in_ready got=%0b exp=1", in_ready); end
      tick();
      idle();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0b exp=1", out_valid); end
      total++; if (out_rd !== 5'd3) begin bad++; $display("FAIL addi_rd got=%0d exp=3", out_rd); end
      total++; if (out_imm !== 32'hFFFFFFFB) begin bad++; $display("FAIL addi_imm got=%h exp=fffffffb", out_imm); end
      total++; if (out_op !== 6'h01) begin bad++; $display("FAIL addi_op got=%h exp=01", out_op); end
      total++; if (out_pc !== 32'h100) begin bad++; $display("FAIL addi_pc got=%h exp=100", out_pc); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got=%0b exp=0", out_valid); end
   endtask

   task automatic test_imm_and_nop();
      offer(32'h110, 32'h30408001);   // op 0x0C: zero-extended
      tick();
      total++; if (out_imm !== 32'h00008001) begin bad++; $display("FAIL zext_imm got=%h exp=00008001", out_imm); end
      offer(32'h114, 32'h3C408001);   // op 0x0F: sign-extended
      tick();
      total++; if (out_imm !== 32'hFFFF8001) begin bad++; $display("FAIL sext_imm got=%h exp=ffff8001", out_imm); end
      offer(32'h118, 32'h49200000);   // op 0x12 rd 9: illegal -> NOP
      tick();
      idle();
      total++; if ({out_op, out_rd} !== 11'h0) begin bad++; $display("FAIL nop_decode got op=%h rd=%0d exp op=00 rd=0", out_op, out_rd); end
      tick();
   endtask

   task automatic test_bypass();
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
      tick();
      wb_addr = 5'd7; wb_data = 32'h1234;
      offer(32'h120, 32'h00270000);   // rs1 = 7 while r7 is being written
      tick();
      total++; if (out_rs1_val !== 32'h1234) begin bad++; $display("FAIL bypass_rs1 got=%h exp=1234", out_rs1_val); end
      wb_en = 1'b0;
      offer(32'h124, 32'h00013800);   // rs1 = 1, rs2 = 7 from storage
      tick();
      total++; if (out_rs1_val !== 32'h55) begin bad++; $display("FAIL rf_rs1 got=%h exp=55", out_rs1_val); end
      total++; if (out_rs2_val !== 32'h1234) begin bad++; $display("FAIL rf_rs2 got=%h exp=1234", out_rs2_val); end
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
      offer(32'h128, 32'h00800000);   // reads r0 while r0 is written
      tick();
      total++; if (out_rs1_val !== 32'h0) begin bad++; $display("FAIL r0_bypass got=%h exp=0", out_rs1_val); end
      wb_en = 1'b0;
      tick();
      idle();
      total++; if (out_rs1_val !== 32'h0) begin bad++; $display("FAIL r0_stored got=%h exp=0", out_rs1_val); end
      tick();
   endtask

   task automatic test_load_use();
      offer(32'h200, 32'h40A00004);   // LOAD r5
      tick();
      total++; if ({out_valid, out_is_load, out_rd} !== {1'b1, 1'b1, 5'd5}) begin bad++; $display("FAIL load_out got=%0b%0b rd=%0d exp=11 rd=5", out_valid, out_is_load, out_rd); end
      in_valid = 1'b0;
      in_instr = 32'h04C12800;        // ADDI r6,r1: imm bits look like rs2=5
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL itype_no_hazard got=%0b exp=1", in_ready); end
      in_instr = 32'h80002800;        // BEQ rs2=5
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL beq_hazard got=%0b exp=0", in_ready); end
      offer(32'h204, 32'h00C50800);   // ADD r6,r5,r1
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL add_hazard got=%0b exp=0", in_ready); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bubble got=%0b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL after_bubble_ready got=%0b exp=1", in_ready); end
      tick();
      idle();
      total++; if ({out_valid, out_rd, out_pc} !== {1'b1, 5'd6, 32'h204}) begin bad++; $display("FAIL add_issue got v=%0b rd=%0d pc=%h exp v=1 rd=6 pc=204", out_valid, out_rd, out_pc); end
      total++; if (out_rs2_val !== 32'h55) begin bad++; $display("FAIL add_rs2 got=%h exp=55", out_rs2_val); end
      tick();
   endtask

   task automatic test_stall();
      offer(32'h300, 32'h04400001);   // A: ADDI r2,r0,1
      tick();
      out_ready = 1'b0;
      offer(32'h304, 32'h04600002);   // B: ADDI r3,r0,2
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%0b exp=0", i, in_ready); end
         tick();
         total++; if ({out_valid, out_pc, out_imm, out_rd} !== {1'b1, 32'h300, 32'h1, 5'd2}) begin bad++; $display("FAIL stall_hold[%0d] got pc=%h imm=%h exp pc=300 imm=1", i, out_pc, out_imm); end
      end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL unstall_ready got=%0b exp=1", in_ready); end
      tick();
      idle();
      total++; if ({out_valid, out_pc, out_imm, out_rd} !== {1'b1, 32'h304, 32'h2, 5'd3}) begin bad++; $display("FAIL stall_b got pc=%h imm=%h exp pc=304 imm=2", out_pc, out_imm); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_no_dup got=%0b exp=0", out_valid); end
   endtask

   task automatic test_halt();
      offer(32'h400, 32'hFC000000);
      tick();
      offer(32'h404, 32'h04400001);
      total++; if ({out_valid, out_op, out_halted} !== {1'b1, 6'h3F, 1'b1}) begin bad++; $display("FAIL halt_out got v=%0b op=%h h=%0b exp v=1 op=3f h=1", out_valid, out_op, out_halted); end
      for (int i = 0; i < 3; i++) begin
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL halted_ready[%0d] got=%0b exp=0", i, in_ready); end
         tick();
         total++; if ({out_valid, out_halted} !== 2'b01) begin bad++; $display("FAIL halted_state[%0d] got v=%0b h=%0b exp v=0 h=1", i, out_valid, out_halted); end
      end
      flush = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_cycle_ready got=%0b exp=0", in_ready); end
      tick();
      flush = 1'b0;
      idle();
      #1;
      total++; if ({out_halted, out_valid, in_ready} !== 3'b001) begin bad++; $display("FAIL unhalt got h=%0b v=%0b r=%0b exp h=0 v=0 r=1", out_halted, out_valid, in_ready); end
   endtask

   task automatic test_flush_accept();
      out_ready = 1'b0;
      offer(32'h500, 32'h04400001);
      tick();
      flush = 1'b1;
      offer(32'h504, 32'h04600002);
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h77;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0b exp=0", in_ready); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got=%0b exp=0", out_valid); end
      flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
      idle();
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_emit got=%0b exp=0", out_valid); end
      offer(32'h508, 32'h00090000);   // read r9
      tick();
      idle();
      total++; if (out_rs1_val !== 32'h77) begin bad++; $display("FAIL flush_wb got=%h exp=77", out_rs1_val); end
      tick();
   endtask

   task automatic test_reset_midstall();
      out_ready = 1'b0;
      offer(32'h600, 32'h04400003);
      tick();
      offer(32'h604, 32'h04600004);
      rst_n = 1'b0;
      wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hAA;
      tick();
      total++; if ({out_valid, out_halted, out_is_load} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%0b%0b%0b exp=000", out_valid, out_halted, out_is_load); end
      total++; if ({out_pc, out_imm, out_rs1_val, out_rs2_val, out_op, out_rd} !== 139'h0) begin bad++; $display("FAIL rst_data got pc=%h imm=%h rd=%0d exp 0", out_pc, out_imm, out_rd); end
      rst_n = 1'b1; wb_en = 1'b0; out_ready = 1'b1;
      idle();
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_no_emit got=%0b exp=0", out_valid); end
      offer(32'h608, 32'h000A3800);   // rs1 = 10, rs2 = 7
      tick();
      idle();
      total++; if ({out_rs1_val, out_rs2_val} !== 64'h0) begin bad++; $display("FAIL rst_regs got r10=%h r7=%h exp 0", out_rs1_val, out_rs2_val); end
      tick();
   endtask

   initial begin
      test_reset();
      test_addi();
      test_imm_and_nop();
      test_bypass();
      test_load_use();
      test_stall();
      test_halt();
      test_flush_accept();
      test_reset_midstall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter XLEN, default 32: data and PC width.
REQ-002 Parameter NREG, default 32: architectural register count; RAW = log2(NREG).
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 reads as zero and ignores writes.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 in_valid / in_ready  in / out  1 / 1  fetch-to-decode handshake.
REQ-008 in_pc / in_instr  in  XLEN / 32  fetched PC and instruction word.
REQ-009 flush  in  1  discard the held decode result (branch redirect).
REQ-010 wb_en / wb_addr / wb_data  in  1 / RAW / XLEN  register-file write port.
REQ-011 out_valid / out_ready  out / in  1 / 1  decode-to-execute handshake.
REQ-012 out_pc, out_rs1_val, out_rs2_val, out_imm  out  XLEN each  decoded operands.
REQ-013 out_op / out_rd  out  6 / RAW  opcode, destination register.
REQ-014 out_is_load, out_halted  out  1 each  load flag; halt state indicator.

Function
REQ-015 Instruction fields: op[31:26], rd[25:21], rs1[20:16], rs2[15:11], imm[15:0]; register fields are truncated to RAW bits.
REQ-016 Opcode classes: 0x00 R-type (uses rs2); 0x01-0x0F I-type; 0x10 LOAD; 0x11 STORE (uses rs2); 0x20 BEQ (uses rs2); 0x3F HALT; all other opcodes are decoded as NOP with out_op = 0x00 and rd = 0.
REQ-017 out_imm is imm zero-extended for opcodes 0x0C-0x0E and sign-extended to XLEN otherwise.
REQ-018 Register file: 2 read ports, 1 write port; the write takes effect on the clock edge.
REQ-019 Write-through bypass: when wb_en = 1 and wb_addr equals a source register in the same cycle, the read returns wb_data. With ZERO_REG = 1 the bypass never applies to register 0.
REQ-020 Output register advances when out_valid = 0 or out_ready = 1; otherwise all out_* values hold stable.
REQ-021 Load-use hazard: asserted when out_valid, out_is_load, out_rd != 0, and out_rd equals rs1, or equals rs2 for an instruction that uses rs2.
REQ-022 in_ready = state RUN and not flush and not hazard and (out_valid = 0 or out_ready = 1).
REQ-023 Advance with hazard asserted loads a bubble: out_valid becomes 0 for exactly one cycle.
REQ-024 Latency: exactly 1 cycle from in_valid and in_ready to out_valid.
REQ-025 FSM states RUN and HALTED. RUN -> HALTED on acceptance of HALT; the HALT itself is still presented on the output. HALTED -> RUN on flush or reset.
REQ-026 In HALTED, in_ready = 0 and out_halted = 1.
REQ-027 flush clears out_valid on the next edge regardless of out_ready and holds in_ready = 0 during the flush cycle.
REQ-028 flush has priority over a simultaneous accept. A wb write in the flush cycle still commits.

Reset
REQ-029 When rst_n = 0 at an edge: out_valid = 0, all out_* data = 0, out_halted = 0, state = RUN, all registers = 0.
REQ-030 Reset asserted mid-handshake discards the held instruction and any pending write.

Structure
REQ-031 Opcode constants, field bit positions and the class encodings are defined in the shared package isa_defs, used by the execute stage as well.
REQ-032 The register file is a separate sub-module, regfile: parameters XLEN and NREG, 2R1W, bypass inside.
REQ-033 Hazard and in_ready logic are combinational; no combinational path from out_ready to out_* data.

Verification
REQ-034 ADDI r3,r0,-5 (0x04600000|0xFFFB) accepted -> next cycle out_valid = 1, out_rd = 3, out_imm = 0xFFFFFFFB.
REQ-035 wb_en = 1, r7 = 0x1234 in the same cycle a decode reads rs1 = 7 -> out_rs1_val = 0x1234; a write to r0 -> the value read back is still 0.
REQ-036 LOAD r5 on the output, then ADD r6,r5,r1 offered -> in_ready = 0; one bubble cycle (out_valid = 0); ADD is issued on the following cycle.
REQ-037 out_ready held 0 for 3 cycles with a new instruction pending -> outputs stable, in_ready = 0, no instruction lost or duplicated.
REQ-038 HALT accepted -> out_halted = 1, in_ready = 0 indefinitely; flush pulse -> state RUN, out_valid = 0, in_ready = 1.
REQ-039 flush and in_valid asserted together, and rst_n dropped during a stall -> no instruction emitted; all outputs follow REQ-029 values.
